// File: rtl/dense_pkg.sv
// Shared types and constants for the dense-layer
// output serializer and its requantizer.
package dense_pkg;

  localparam int PIX_W     = 8;
  localparam int ACC_W     = 32;
  localparam int ACC_EXT_W = 33;
  localparam int PIX_MIN   = -128;
  localparam int PIX_MAX   = 127;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/dense_out_serializer_if.sv
// Load port (parallel sums + bias) and pixel
// stream of the dense-layer output serializer.
interface dense_out_serializer_if
  import dense_pkg::*;
#(
  parameter int NUM_TREES = 10
);

  logic [ACC_W*NUM_TREES-1:0] sums_in;
  logic [ACC_W*NUM_TREES-1:0] bias;
  logic                       sums_valid;
  logic                       in_ready;

  logic signed [PIX_W-1:0]    pixel_out;
  logic                       pixel_valid;
  logic                       pixel_ready;

  logic                       frame_done;
  logic                       overrun;

  modport master (
    output sums_in,
    output bias,
    output sums_valid,
    input  in_ready,
    input  pixel_out,
    input  pixel_valid,
    output pixel_ready,
    input  frame_done,
    input  overrun
  );

  modport slave (
    input  sums_in,
    input  bias,
    input  sums_valid,
    output in_ready,
    output pixel_out,
    output pixel_valid,
    input  pixel_ready,
    output frame_done,
    output overrun
  );

endinterface

// File: rtl/dense_requant.sv
// Combinational requantizer: bias add, rounding
// arithmetic shift, optional ReLU, 8-bit saturation.
module dense_requant
  import dense_pkg::*;
#(
  parameter int SHIFT = 8,
  parameter bit RELU  = 1'b1
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic signed [ACC_W-1:0] bias,
  output logic signed [PIX_W-1:0] pixel
);

  // One guard bit above the 33-bit sum so the
  // rounding increment can never wrap.
  localparam int XW = ACC_EXT_W + 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [XW-1:0] RND =
    (SHIFT > 0) ? (XW'(1) << RS) : '0;
  localparam logic signed [XW-1:0] MAXV =
    XW'(PIX_MAX);
  localparam logic signed [XW-1:0] MINV =
    XW'(PIX_MIN);

  logic signed [XW-1:0] t;
  logic signed [XW-1:0] r;

  always_comb begin
    t = XW'(sum) + XW'(bias);
    r = (t + RND) >>> SHIFT;
    if (RELU && r < 0)
      r = '0;
    if (r > MAXV)
      pixel = PIX_W'(MAXV);
    else if (r < MINV)
      pixel = PIX_W'(MINV);
    else
      pixel = PIX_W'(r);
  end

endmodule

// File: rtl/dense_out_serializer.sv
// Captures NUM_TREES sums in one strobe and streams
// them out as requantized 8-bit pixels, tree 0 first.
module dense_out_serializer
  import dense_pkg::*;
#(
  parameter int NUM_TREES = 10,
  parameter int SHIFT     = 8,
  parameter bit RELU      = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  dense_out_serializer_if.slave  bus
);

  localparam int IW =
    (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NUM_TREES - 1);

  state_t                  state;
  logic [IW-1:0]           idx;
  logic signed [ACC_W-1:0] sum_buf  [NUM_TREES];
  logic signed [ACC_W-1:0] bias_buf [NUM_TREES];
  logic                    done_q;
  logic                    ovr_q;

  logic                    emit;
  logic                    last;
  logic                    hs;
  logic                    rdy;
  logic                    load;
  logic signed [PIX_W-1:0] q_pix;

  assign emit = (state == EMIT);
  assign last = (idx == LAST);
  assign hs   = emit & bus.pixel_ready;
  // Last-pixel handshake frees buf, so a new load
  // may land in the same cycle.
  assign rdy  = ~emit | (last & bus.pixel_ready);
  assign load = bus.sums_valid & rdy;

  dense_requant #(
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_requant (
    .sum   (sum_buf[idx]),
    .bias  (bias_buf[idx]),
    .pixel (q_pix)
  );

  assign bus.in_ready    = rdy;
  assign bus.pixel_valid = emit;
  assign bus.pixel_out   = emit ? q_pix : '0;
  assign bus.frame_done  = done_q;
  assign bus.overrun     = ovr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      for (int i = 0; i < NUM_TREES; i++) begin
        sum_buf[i]  <= '0;
        bias_buf[i] <= '0;
      end
    end else begin
      done_q <= hs & last;
      if (bus.sums_valid & ~rdy)
        ovr_q <= 1'b1;
      if (load) begin
        state <= EMIT;
        idx   <= '0;
        for (int i = 0; i < NUM_TREES; i++) begin
          sum_buf[i]  <= bus.sums_in[ACC_W*i +: ACC_W];
          bias_buf[i] <= bus.bias[ACC_W*i +: ACC_W];
        end
      end else if (hs) begin
        unique case (1'b1)
          last:    state <= IDLE;
          default: idx   <= idx + 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dense_out_serializer.sv
// Scoreboard bench: linear and ReLU instances share
// stimulus; a real-arithmetic model predicts pixels.
module tb_dense_out_serializer;
  import dense_pkg::*;

  localparam int N  = 4;
  localparam int SH = 8;
  localparam int W  = 32 * N;

  typedef struct {
    int s;
    int b;
    bit last;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  dense_out_serializer_if #(.NUM_TREES(N)) a ();
  dense_out_serializer_if #(.NUM_TREES(N)) b ();

  assign b.sums_in     = a.sums_in;
  assign b.bias        = a.bias;
  assign b.sums_valid  = a.sums_valid;
  assign b.pixel_ready = a.pixel_ready;

  dense_out_serializer #(
    .NUM_TREES (N),
    .SHIFT     (SH),
    .RELU      (1'b0)
  ) u_lin (
    .clock (clock),
    .reset (reset),
    .bus   (a.slave)
  );

  dense_out_serializer #(
    .NUM_TREES (N),
    .SHIFT     (SH),
    .RELU      (1'b1)
  ) u_relu (
    .clock (clock),
    .reset (reset),
    .bus   (b.slave)
  );

  item_t exp_q[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  bit    ov_exp = 1'b0;
  bit    fd_exp = 1'b0;

  // round(x / 2^SH) with halves going up, then
  // optional ReLU and clamp to the pixel range
  function automatic int ref_pix(
    input int s, input int bs, input bit relu
  );
    real x;
    int  t;
    x = (real'(s) + real'(bs)) / real'(1 << SH);
    t = $rtoi($floor(x + 0.5));
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  task automatic chk(
    input string name,
    input logic signed [63:0] act,
    input logic signed [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    bit    ir_exp;
    bit    hs;
    item_t it;
    if (!reset) begin
      chk("rst_valid_lin", 64'(a.pixel_valid), 0);
      chk("rst_valid_relu", 64'(b.pixel_valid), 0);
      chk("rst_pix_lin", 64'(a.pixel_out), 0);
      chk("rst_pix_relu", 64'(b.pixel_out), 0);
      chk("rst_done", 64'(a.frame_done), 0);
      chk("rst_ovr", 64'(a.overrun), 0);
      chk("rst_ready", 64'(a.in_ready), 1);
      exp_q.delete();
      ov_exp = 1'b0;
      fd_exp = 1'b0;
    end else begin
      ir_exp = (exp_q.size() == 0) ||
               (exp_q.size() == 1 && a.pixel_ready);
      chk("in_ready_lin", 64'(a.in_ready), 64'(ir_exp));
      chk("in_ready_relu", 64'(b.in_ready), 64'(ir_exp));
      chk("valid_lin", 64'(a.pixel_valid),
          64'(exp_q.size() != 0));
      chk("valid_relu", 64'(b.pixel_valid),
          64'(exp_q.size() != 0));
      chk("done_lin", 64'(a.frame_done), 64'(fd_exp));
      chk("done_relu", 64'(b.frame_done), 64'(fd_exp));
      chk("ovr_lin", 64'(a.overrun), 64'(ov_exp));
      chk("ovr_relu", 64'(b.overrun), 64'(ov_exp));
      hs = 1'b0;
      if (exp_q.size() != 0) begin
        it = exp_q[0];
        chk("pix_lin", 64'(a.pixel_out),
            64'(ref_pix(it.s, it.b, 1'b0)));
        chk("pix_relu", 64'(b.pixel_out),
            64'(ref_pix(it.s, it.b, 1'b1)));
        hs = a.pixel_ready;
      end
      fd_exp = 1'b0;
      if (a.sums_valid && !ir_exp) ov_exp = 1'b1;
      if (hs) begin
        it = exp_q.pop_front();
        fd_exp = it.last;
      end
      if (a.sums_valid && ir_exp) begin
        for (int i = 0; i < N; i++) begin
          it.s    = a.sums_in[32*i +: 32];
          it.b    = a.bias[32*i +: 32];
          it.last = (i == N - 1);
          exp_q.push_back(it);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] pack4(
    input int v0, input int v1,
    input int v2, input int v3
  );
    return {v3, v2, v1, v0};
  endfunction

  task automatic send(
    input logic [W-1:0] s, input logic [W-1:0] bs
  );
    a.sums_in    = s;
    a.bias       = bs;
    a.sums_valid = 1'b1;
    tick();
    a.sums_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: %0d pixels left, need 0",
               exp_q.size());
    end
    tick();
  endtask

  logic [W-1:0] s0;
  logic [W-1:0] z;

  initial begin
    z = '0;
    s0 = pack4(384, -384, -40000, 32'sh7FFFFFFF);
    a.sums_valid  = 1'b0;
    a.sums_in     = '0;
    a.bias        = '0;
    a.pixel_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    a.pixel_ready = 1'b1;
    send(s0, z);
    wait_idle();

    send(pack4(100, 32'sh7FFFFFFF, -1000, 32'sh80000000),
         pack4(156, 32'sh7FFFFFFF, -700, 32'sh80000000));
    wait_idle();

    send(pack4(1000, -2000, 30000, 127), pack4(5, 6, 7, 1));
    for (int i = 0; i < 12; i++) begin
      a.pixel_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    a.pixel_ready = 1'b1;
    wait_idle();

    send(s0, z);
    repeat (3) tick();
    send(pack4(640, -640, 129, -129), pack4(0, 0, 0, 0));
    wait_idle();

    send(pack4(5000, 6000, -7000, 8000), z);
    tick();
    send(pack4(1, 2, 3, 4), z);
    wait_idle();

    send(s0, pack4(10, 20, 30, 40));
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    send(pack4(-256, 256, 511, -513), z);
    wait_idle();

    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] rs;
      logic [W-1:0] rb;
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 2) == 0)
          rs[32*j +: 32] = $urandom;
        else
          rs[32*j +: 32] =
            32'($signed($urandom_range(0, 80000)) - 40000);
        rb[32*j +: 32] =
          32'($signed($urandom_range(0, 4000)) - 2000);
      end
      a.sums_in     = rs;
      a.bias        = rb;
      a.sums_valid  = ($urandom_range(0, 5) == 0);
      a.pixel_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    a.sums_valid  = 1'b0;
    a.pixel_ready = 1'b1;
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dense_out_serializer.md
# dense_out_serializer

Downstream stage of the dense (fully connected) layer. It captures the NUM_TREES parallel 32-bit multiply-adder sums in one strobe, then requantizes each sum to a signed 8-bit pixel: bias add, rounding arithmetic shift, optional ReLU, saturation. It emits the pixels one per cycle on a valid/ready stream that feeds the next layer's 8-bit `pixel_in`.

## Interface
Parameters:
- NUM_TREES, 10, number of parallel sums per load (≥1)
- SHIFT, 8, right-shift applied after bias add (0..31)
- RELU, 1, 1 = clamp negatives to 0 before saturation

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- sums_in  in  32*NUM_TREES  signed sums; tree i at [32i+31:32i]
- sums_valid  in  1  sums_in valid this cycle
- in_ready  out  1  load accepted this cycle if sums_valid=1
- bias  in  32*NUM_TREES  signed per-tree bias; sampled together with sums_in
- pixel_out  out  8  quantized signed pixel
- pixel_valid  out  1  pixel_out valid
- pixel_ready  in  1  downstream accepts pixel_out
- frame_done  out  1  one-cycle pulse after the last pixel of a load is accepted
- overrun  out  1  sticky: sums_valid=1 while in_ready=0

## Operation
- States: IDLE and EMIT. Index counter idx runs 0..NUM_TREES-1, width $clog2(NUM_TREES) (minimum 1).
- IDLE: in_ready=1. On sums_valid, the block registers all sums and biases into buf, sets idx=0 and moves to EMIT.
- EMIT: pixel_valid=1 and pixel_out=q(buf[idx]). On a handshake (pixel_valid & pixel_ready):
  - if idx<NUM_TREES-1, idx increments;
  - otherwise frame_done pulses next cycle and the block returns to IDLE.
- Without pixel_ready, pixel_out and idx hold stable.
- Back-to-back loads: in_ready = IDLE | (EMIT & idx==NUM_TREES-1 & pixel_ready). When sums_valid arrives in that last-handshake cycle, the new load is captured, state stays EMIT, idx=0, and frame_done still pulses.
- Overrun: sums_valid while in_ready=0 sets overrun=1. That data is dropped and buf is untouched. Only reset clears overrun.
- Quantize q(x):
  - t = sext33(x) + sext33(bias), 33-bit, no wrap.
  - If SHIFT>0, t += 1<<(SHIFT-1) (round half up), then t >>>= SHIFT.
  - If RELU and t<0, t=0.
  - Saturate to [-128,127].
- Pixel order: tree 0 first, tree NUM_TREES-1 last.

## Timing
- Reset values: pixel_valid=0, pixel_out=0, frame_done=0, overrun=0, in_ready=1 (IDLE). buf and idx are cleared to 0.
- Reset asserted mid-EMIT aborts the frame immediately, with no frame_done. The first cycle after release is IDLE.
- Latency: load accepted at edge N gives pixel_valid=1 with tree 0 after edge N (cycle N+1).
- With pixel_ready held at 1, one pixel per cycle; a frame takes NUM_TREES cycles.
- frame_done is high for exactly the cycle after the final handshake.
- pixel_out is driven from registered buf through combinational q(). Its path is 33-bit add + shift + clamp; register pixel_out instead if timing fails, with no latency change at the interface.
- in_ready depends combinationally on pixel_ready (last-pixel case only).

## Structure
- Shared package (dense_pkg) holds:
  - PIX_W=8, ACC_W=32, ACC_EXT_W=33, PIX_MIN=-128, PIX_MAX=127
  - state enum {IDLE, EMIT}
- Sub-module dense_requant: combinational q() with parameters SHIFT and RELU; input 32-bit sum and bias, output 8-bit pixel. One instance, muxed by idx.
- Top holds buf, the FSM, idx, and the overrun/frame_done flags.

## Test plan
- NUM_TREES=4, SHIFT=8, RELU=0, bias=0, sums {384, -384, -40000, 0x7FFFFFFF}, pixel_ready=1 → pixels 2, -1, -128, 127 on consecutive cycles starting 1 cycle after load; frame_done pulses after the 4th; in_ready low during EMIT.
- RELU=1, same sums → 2, 0, 0, 127.
- Bias path: sum 100, bias 156, SHIFT=8 → 1; sum 0x7FFFFFFF, bias 0x7FFFFFFF → 127 (no wrap to negative).
- Backpressure: pixel_ready toggled 1,0,0,1,... → pixel_out and idx stable while ready=0; all 4 pixels delivered once, in order.
- Back-to-back load: sums_valid asserted in the last-handshake cycle → frame_done pulses, the next frame's tree 0 appears the following cycle, overrun stays 0. sums_valid mid-frame → overrun=1 and the current frame is unaffected.
- Reset (reset=0) asserted during idx=2 → outputs at reset values immediately, no frame_done. After release, a new load outputs from tree 0.
